fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the five-stage RV32I core. It consumes the current PC from the PC controller and drives it to a synchronous instruction memory with one-cycle read latency. It pairs each returned instruction with the PC that fetched it and presents both to the decode stage. It handles decode-stage stalls with a one-entry hold buffer, and it handles branch flushes from EX by squashing the wrong-path instruction.

---
 rtl/core_pkg.sv | 16 +
 rtl/Adder32.sv | 12 +
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the five-stage RV32I core.
package core_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- the canonical bubble
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    // Fetch hold-buffer control: RUN streams, HOLD means the buffer already
    // owns whatever was captured on the first stalled edge.
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/Adder32.sv
// Plain 32-bit adder with carry-in; the sum wraps modulo 2^32.
module Adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s
);

    // Carry-out is not needed by any user, so only the sum is produced.
    assign s = a + b + {31'b0, ci};

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register. Pairs each one-cycle-latency imem word
// with the PC that fetched it, rides out decode stalls with a one-entry hold
// buffer, and squashes the wrong-path fetch on a branch flush.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP      = NOP_INST,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] imem_addr,
    output logic            pc_load,
    output logic [XLEN-1:0] inst_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d
);

    localparam logic [XLEN-1:0] RESET_PC4 = RESET_PC + 32'd4;

    // PC whose data is on imem_rdata this cycle, and whether it is real
    logic [XLEN-1:0] pc_f_q;
    logic            f_valid_q;
    // hold buffer
    logic [XLEN-1:0] hold_inst_q;
    logic            hold_valid_q;
    fetch_state_t    state_q;
    // IF/ID register
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pcplus4_q;
    logic            valid_q;

    logic [XLEN-1:0] pc_f_plus4;

    // The memory sees the live PC; a flush must redirect even while stalled.
    assign imem_addr = pc;
    assign pc_load   = ~stall | flush;

    Adder32 u_pc_inc (
        .a  (pc_f_q),
        .b  (32'd4),
        .ci (1'b0),
        .s  (pc_f_plus4)
    );

    // Fetch/hold FSM and IF/ID register, priority: reset, flush, stall, advance
    always_ff @(posedge clk) begin
        if (!rstn) begin
            inst_q       <= NOP;
            pc_q         <= RESET_PC;
            pcplus4_q    <= RESET_PC4;
            valid_q      <= 1'b0;
            pc_f_q       <= RESET_PC;
            f_valid_q    <= 1'b0;
            hold_inst_q  <= NOP;
            hold_valid_q <= 1'b0;
            state_q      <= RUN;
        end else if (flush) begin
            // The in-flight fetch and any held word are wrong-path.
            inst_q       <= NOP;
            pc_q         <= RESET_PC;
            pcplus4_q    <= RESET_PC4;
            valid_q      <= 1'b0;
            pc_f_q       <= pc;
            f_valid_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            state_q      <= RUN;
        end else if (stall) begin
            // Address does not advance, so next cycle imem_rdata will be
            // mem[pc], not mem[pc_f]; grab the pc_f word now, only once.
            if (state_q == RUN) begin
                if (f_valid_q) begin
                    hold_inst_q  <= imem_rdata;
                    hold_valid_q <= 1'b1;
                end
                state_q <= HOLD;
            end
        end else begin
            inst_q       <= hold_valid_q ? hold_inst_q : imem_rdata;
            pc_q         <= pc_f_q;
            pcplus4_q    <= pc_f_plus4;
            valid_q      <= f_valid_q;
            pc_f_q       <= pc;
            f_valid_q    <= 1'b1;
            hold_valid_q <= 1'b0;
            state_q      <= RUN;
        end
    end

    assign inst_d    = inst_q;
    assign pc_d      = pc_q;
    assign pcplus4_d = pcplus4_q;
    assign valid_d   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a PC-controller/imem environment plus a
// transaction-level reference model (queue of fetched-but-undelivered PCs).
module tb_fetch_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic        pc_load;
    logic [31:0] inst_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;

    fetch_stage dut (
        .clk        (clk),
        .rstn       (rstn),
        .pc         (pc),
        .stall      (stall),
        .flush      (flush),
        .imem_rdata (imem_rdata),
        .imem_addr  (imem_addr),
        .pc_load    (pc_load),
        .inst_d     (inst_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // synchronous instruction memory, one-cycle read latency
    always @(posedge clk) imem_rdata <= memf(imem_addr);

    int total = 0;
    int bad   = 0;

    // reference model: PCs consumed by the fetch stage, not yet in decode
    logic [31:0] q[$];
    logic        exp_v, exp_full;
    logic [31:0] exp_pc, exp_inst, exp_pp4;
    logic        got_load, exp_load;
    logic [31:0] got_addr;

    function automatic logic [96:0] dut_out();
        return exp_full ? {valid_d, pc_d, inst_d, pcplus4_d} : {valid_d, 96'h0};
    endfunction

    function automatic logic [96:0] exp_out();
        return exp_full ? {exp_v, exp_pc, exp_inst, exp_pp4} : {exp_v, 96'h0};
    endfunction

    // One clock: drive inputs, sample combinational outputs, clock, update model,
    // then act as the PC controller for the next cycle.
    task automatic cycle(input bit r, input bit s, input bit f, input logic [31:0] tgt);
        logic [31:0] a;
        rstn = ~r; stall = s; flush = f;
        #1;
        got_load = pc_load; got_addr = imem_addr; exp_load = ~s | f;
        @(posedge clk);
        if (r || f) begin
            q.delete();
            exp_v = 1'b0; exp_full = 1'b1;
            exp_pc = 32'h0; exp_inst = NOP_INST; exp_pp4 = 32'h4;
        end else if (!s) begin
            if (q.size() > 0) begin
                a = q.pop_front();
                exp_v = 1'b1; exp_full = 1'b1;
                exp_pc = a; exp_inst = memf(a); exp_pp4 = a + 32'd4;
            end else begin
                exp_v = 1'b0; exp_full = 1'b0;
            end
            q.push_back(pc);
        end
        #1;
        if (r) pc = 32'h0;
        else if (f) pc = tgt;
        else if (!s) pc = pc + 32'd4;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        total++;
        if ({valid_d, pc_d, inst_d, pcplus4_d} !== {1'b0, 32'h0, 32'h0000_0013, 32'h4}) begin
            bad++;
            $display("FAIL reset: got v=%0b pc=%h inst=%h pp4=%h want v=0 pc=0 inst=00000013 pp4=4",
                     valid_d, pc_d, inst_d, pcplus4_d);
        end
    endtask

    task automatic test_freerun();
        cycle(0, 0, 0, 0);
        total++;
        if (valid_d !== 1'b0) begin
            bad++; $display("FAIL freerun_first_bubble: got v=%0b want 0", valid_d);
        end
        cycle(0, 0, 0, 0);
        total++;
        if ({valid_d, pc_d, inst_d} !== {1'b1, 32'h0, 32'hA5A5_0000}) begin
            bad++;
            $display("FAIL freerun_edge2: got v=%0b pc=%h inst=%h want v=1 pc=0 inst=a5a50000",
                     valid_d, pc_d, inst_d);
        end
        cycle(0, 0, 0, 0);
        total++;
        if ({pc_d, pcplus4_d} !== {32'h4, 32'h8} || dut_out() !== exp_out()) begin
            bad++; $display("FAIL freerun_edge3: got %h want %h", dut_out(), exp_out());
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            total++;
            if (got_load !== 1'b0 || got_addr !== 32'hC) begin
                bad++; $display("FAIL stall_pc_load: got load=%0b addr=%h want load=0 addr=c", got_load, got_addr);
            end
            total++;
            if (inst_d !== 32'hA5A5_0004 || pc_d !== 32'h4) begin
                bad++; $display("FAIL stall_hold: got pc=%h inst=%h want pc=4 inst=a5a50004", pc_d, inst_d);
            end
        end
        cycle(0, 0, 0, 0);
        total++;
        if ({valid_d, pc_d, inst_d} !== {1'b1, 32'h8, 32'hA5A5_0008}) begin
            bad++; $display("FAIL stall_release: got v=%0b pc=%h inst=%h want v=1 pc=8 inst=a5a50008",
                            valid_d, pc_d, inst_d);
        end
        cycle(0, 0, 0, 0);
        total++;
        if ({valid_d, pc_d, inst_d} !== {1'b1, 32'hC, 32'hA5A5_000C}) begin
            bad++; $display("FAIL stall_next: got v=%0b pc=%h inst=%h want v=1 pc=c inst=a5a5000c",
                            valid_d, pc_d, inst_d);
        end
    endtask

    task automatic test_flush();
        cycle(0, 0, 1, 32'h100);
        total++;
        if ({valid_d, inst_d} !== {1'b0, 32'h0000_0013}) begin
            bad++; $display("FAIL flush_bubble: got v=%0b inst=%h want v=0 inst=00000013", valid_d, inst_d);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            total++;
            if (dut_out() !== exp_out() || (valid_d === 1'b1 && inst_d === 32'hA5A5_0010)) begin
                bad++; $display("FAIL flush_redirect: got %h want %h", dut_out(), exp_out());
            end
        end
        total++;
        if (pc_d !== 32'h104 || valid_d !== 1'b1) begin
            bad++; $display("FAIL flush_target: got pc=%h v=%0b want pc=104 v=1", pc_d, valid_d);
        end
    endtask

    task automatic test_flush_in_hold();
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 32'h200);
        total++;
        if (got_load !== 1'b1 || valid_d !== 1'b0 || inst_d !== 32'h0000_0013) begin
            bad++; $display("FAIL flush_hold: got load=%0b v=%0b inst=%h want load=1 v=0 inst=00000013",
                            got_load, valid_d, inst_d);
        end
        // a fresh stall after the flush must behave as RUN (no stale capture)
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            total++;
            if (dut_out() !== exp_out()) begin
                bad++; $display("FAIL flush_hold_after: got %h want %h", dut_out(), exp_out());
            end
        end
        total++;
        if (pc_d !== 32'h204 || inst_d !== memf(32'h204)) begin
            bad++; $display("FAIL flush_hold_stream: got pc=%h inst=%h want pc=204", pc_d, inst_d);
        end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        total++;
        if ({valid_d, pc_d, pcplus4_d} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
            bad++; $display("FAIL wrap: got v=%0b pc=%h pp4=%h want v=1 pc=fffffffc pp4=0",
                            valid_d, pc_d, pcplus4_d);
        end
        cycle(0, 0, 0, 0);
        total++;
        if (dut_out() !== exp_out()) begin
            bad++; $display("FAIL wrap_next: got %h want %h", dut_out(), exp_out());
        end
    endtask

    task automatic test_reset_mid_stall();
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        total++;
        if ({valid_d, pc_d, inst_d, pcplus4_d} !== {1'b0, 32'h0, 32'h0000_0013, 32'h4}) begin
            bad++; $display("FAIL reset_mid_stall: got v=%0b pc=%h inst=%h pp4=%h want v=0 pc=0 inst=00000013 pp4=4",
                            valid_d, pc_d, inst_d, pcplus4_d);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            total++;
            if (dut_out() !== exp_out()) begin
                bad++; $display("FAIL reset_release: got %h want %h", dut_out(), exp_out());
            end
        end
    endtask

    task automatic test_random();
        bit r, s, f;
        logic [31:0] t;
        for (int i = 0; i < 500; i++) begin
            r = ($urandom_range(99) < 2);
            s = ($urandom_range(99) < 35);
            f = ($urandom_range(99) < 8);
            t = {$urandom_range(32'h3FFF), 2'b00};
            cycle(r, s, f, t);
            total++;
            if (got_load !== exp_load) begin
                bad++; $display("FAIL rand_pc_load: cyc %0d got %0b want %0b", i, got_load, exp_load);
            end
            total++;
            if (dut_out() !== exp_out()) begin
                bad++; $display("FAIL rand_out: cyc %0d got %h want %h", i, dut_out(), exp_out());
            end
        end
    endtask

    initial begin
        rstn = 1'b0; pc = 32'h0; stall = 1'b0; flush = 1'b0;
        exp_v = 1'b0; exp_full = 1'b0;
        exp_pc = 32'h0; exp_inst = NOP_INST; exp_pp4 = 32'h4;
        test_reset();
        test_freerun();
        test_stall();
        test_flush();
        test_flush_in_hold();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
